// File: rtl/keyboard_pkg.sv
// Shared types and constants for the PS/2-to-Spectrum keyboard matrix.
package keyboard_pkg;

    localparam int unsigned ROWS = 8;
    localparam int unsigned COLS = 5;

    localparam logic [7:0] KB_RELEASE = 8'hF0;
    localparam logic [7:0] KB_EXTEND  = 8'hE0;
    localparam logic [7:0] KB_F5      = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
        logic       valid;
    } key_pos_t;

    function automatic key_pos_t kpos(input logic [2:0] r, input logic [2:0] c);
        return '{row: r, col: c, valid: 1'b1};
    endfunction

endpackage

// File: rtl/keyboard_keymap.sv
// Scan-code (set 2) to Spectrum matrix position lookup; combos use the secondary slot.
module keyboard_keymap
    import keyboard_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output key_pos_t   primary,
    output key_pos_t   secondary
);

    always_comb begin
        primary   = '0;
        secondary = '0;
        if (ext) begin
            // E0 arrows are Caps Shift plus the cursor digit
            case (code)
                8'h6B:   begin primary = kpos(3'd0, 3'd0); secondary = kpos(3'd3, 3'd4); end
                8'h72:   begin primary = kpos(3'd0, 3'd0); secondary = kpos(3'd4, 3'd4); end
                8'h75:   begin primary = kpos(3'd0, 3'd0); secondary = kpos(3'd4, 3'd3); end
                8'h74:   begin primary = kpos(3'd0, 3'd0); secondary = kpos(3'd4, 3'd2); end
                default: ;
            endcase
        end else begin
            case (code)
                8'h12:   primary = kpos(3'd0, 3'd0);
                8'h1A:   primary = kpos(3'd0, 3'd1);
                8'h22:   primary = kpos(3'd0, 3'd2);
                8'h21:   primary = kpos(3'd0, 3'd3);
                8'h2A:   primary = kpos(3'd0, 3'd4);
                8'h1C:   primary = kpos(3'd1, 3'd0);
                8'h1B:   primary = kpos(3'd1, 3'd1);
                8'h23:   primary = kpos(3'd1, 3'd2);
                8'h2B:   primary = kpos(3'd1, 3'd3);
                8'h34:   primary = kpos(3'd1, 3'd4);
                8'h15:   primary = kpos(3'd2, 3'd0);
                8'h1D:   primary = kpos(3'd2, 3'd1);
                8'h24:   primary = kpos(3'd2, 3'd2);
                8'h2D:   primary = kpos(3'd2, 3'd3);
                8'h2C:   primary = kpos(3'd2, 3'd4);
                8'h16:   primary = kpos(3'd3, 3'd0);
                8'h1E:   primary = kpos(3'd3, 3'd1);
                8'h26:   primary = kpos(3'd3, 3'd2);
                8'h25:   primary = kpos(3'd3, 3'd3);
                8'h2E:   primary = kpos(3'd3, 3'd4);
                8'h45:   primary = kpos(3'd4, 3'd0);
                8'h46:   primary = kpos(3'd4, 3'd1);
                8'h3E:   primary = kpos(3'd4, 3'd2);
                8'h3D:   primary = kpos(3'd4, 3'd3);
                8'h36:   primary = kpos(3'd4, 3'd4);
                8'h4D:   primary = kpos(3'd5, 3'd0);
                8'h44:   primary = kpos(3'd5, 3'd1);
                8'h43:   primary = kpos(3'd5, 3'd2);
                8'h3C:   primary = kpos(3'd5, 3'd3);
                8'h35:   primary = kpos(3'd5, 3'd4);
                8'h5A:   primary = kpos(3'd6, 3'd0);
                8'h4B:   primary = kpos(3'd6, 3'd1);
                8'h42:   primary = kpos(3'd6, 3'd2);
                8'h3B:   primary = kpos(3'd6, 3'd3);
                8'h33:   primary = kpos(3'd6, 3'd4);
                8'h29:   primary = kpos(3'd7, 3'd0);
                8'h14:   primary = kpos(3'd7, 3'd1);
                8'h3A:   primary = kpos(3'd7, 3'd2);
                8'h31:   primary = kpos(3'd7, 3'd3);
                8'h32:   primary = kpos(3'd7, 3'd4);
                8'h66:   begin primary = kpos(3'd0, 3'd0); secondary = kpos(3'd4, 3'd0); end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/keyboard.sv
// PS/2 receiver feeding an 8x5 Spectrum key matrix; KEYBOARD_PARITY_EN enables odd-parity checking.
module keyboard
    import keyboard_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Ck,
    input  logic       ps2D,
    input  logic [7:0] row,
    output logic [4:0] col,
    output logic       f5
);

    logic [1:0]                     ck_s;
    logic [1:0]                     d_s;
    logic                           ck_prev;
    logic                           ck_fall;
    logic                           frame_ok;
    rx_state_e                      state;
    logic [2:0]                     bit_cnt;
    logic [7:0]                     shreg;
    logic [15:0]                    idle_cnt;
    logic                           byte_vld;
    logic [7:0]                     rx_byte;
    logic                           rel;
    logic                           ext;
    logic [ROWS-1:0][COLS-1:0]      matrix;
    logic [ROWS-1:0][COLS-1:0]      hit;
    key_pos_t                       primary;
    key_pos_t                       secondary;

    // Two-flop synchronisers plus a delay flop for clock falling-edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ck_s    <= 2'b11;
            d_s     <= 2'b11;
            ck_prev <= 1'b1;
        end else begin
            ck_s    <= {ck_s[0], ps2Ck};
            d_s     <= {d_s[0], ps2D};
            ck_prev <= ck_s[1];
        end
    end

    assign ck_fall = ck_prev & ~ck_s[1];

`ifdef KEYBOARD_PARITY_EN
    logic par_bit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                 par_bit <= 1'b0;
        else if (ck_fall && state == ST_PARITY)     par_bit <= d_s[1];
    end

    assign frame_ok = d_s[1] & (^{shreg, par_bit});
`else
    assign frame_ok = d_s[1];
`endif

    // Frame receiver; an idle watchdog abandons stalled frames
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            idle_cnt <= '0;
            byte_vld <= 1'b0;
            rx_byte  <= '0;
        end else begin
            byte_vld <= 1'b0;
            if (state == ST_IDLE || ck_fall) idle_cnt <= '0;
            else                             idle_cnt <= idle_cnt + 16'd1;

            if (state != ST_IDLE && !ck_fall && idle_cnt == TIMEOUT - 16'd1) begin
                state <= ST_IDLE;
            end else if (ck_fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!d_s[1]) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {d_s[1], shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: state <= ST_STOP;
                    ST_STOP: begin
                        state <= ST_IDLE;
                        if (frame_ok) begin
                            byte_vld <= 1'b1;
                            rx_byte  <= shreg;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    keyboard_keymap keymap (
        .ext       (ext),
        .code      (rx_byte),
        .primary   (primary),
        .secondary (secondary)
    );

    always_comb begin
        hit = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                hit[r][c] = (primary.valid   && primary.row   == 3'(r) && primary.col   == 3'(c)) ||
                            (secondary.valid && secondary.row == 3'(r) && secondary.col == 3'(c));
            end
        end
    end

    // Prefix flags and matrix update, one clock after the byte is accepted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            matrix <= '1;
            rel    <= 1'b0;
            ext    <= 1'b0;
            f5     <= 1'b0;
        end else if (byte_vld) begin
            if (rx_byte == KB_RELEASE) begin
                rel <= 1'b1;
            end else if (rx_byte == KB_EXTEND) begin
                ext <= 1'b1;
            end else begin
                rel <= 1'b0;
                ext <= 1'b0;
                if (!ext && rx_byte == KB_F5) f5 <= ~rel;
                for (int unsigned r = 0; r < ROWS; r++) begin
                    for (int unsigned c = 0; c < COLS; c++) begin
                        if (hit[r][c]) matrix[r][c] <= rel;
                    end
                end
            end
        end
    end

    always_comb begin
        col = 5'h1F;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (!row[r]) col = col & matrix[r];
        end
    end

endmodule

// File: tb/tb_keyboard.sv
// Randomized PS/2 frame stimulus checked every cycle against a table-driven matrix model.
module tb_keyboard;

    localparam logic [15:0] TO = 16'd200;
    localparam int          H  = 10;
`ifdef KEYBOARD_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clock;
    logic       reset;
    logic       ps2Ck;
    logic       ps2D;
    logic [7:0] row;
    logic [4:0] col;
    logic       f5;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Spectrum layout by PS/2 set-2 code; column 0 is the outermost key
    logic [7:0] layout [0:7][0:4] = '{
        '{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A},
        '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
        '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
        '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
        '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
        '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
        '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
        '{8'h29, 8'h14, 8'h3A, 8'h31, 8'h32}
    };

    bit m_mat [0:7][0:4];
    bit m_rel;
    bit m_ext;
    bit m_f5;

    keyboard #(.TIMEOUT(TO)) dut (
        .clock (clock),
        .reset (reset),
        .ps2Ck (ps2Ck),
        .ps2D  (ps2D),
        .row   (row),
        .col   (col),
        .f5    (f5)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++) m_mat[r][c] = 1'b1;
        m_rel = 1'b0;
        m_ext = 1'b0;
        m_f5  = 1'b0;
    endfunction

    function automatic bit key_hit(input logic [7:0] code, input bit ext, input int r, input int c);
        logic [7:0] digit;
        digit = 8'h00;
        if (ext) begin
            case (code)
                8'h6B:   digit = 8'h2E;
                8'h72:   digit = 8'h36;
                8'h75:   digit = 8'h3D;
                8'h74:   digit = 8'h3E;
                default: digit = 8'h00;
            endcase
            return digit != 8'h00 && ((r == 0 && c == 0) || layout[r][c] == digit);
        end
        if (code == 8'h66) return (r == 0 && c == 0) || layout[r][c] == 8'h45;
        return layout[r][c] == code;
    endfunction

    function automatic void model_byte(input logic [7:0] code);
        if (code == 8'hF0) m_rel = 1'b1;
        else if (code == 8'hE0) m_ext = 1'b1;
        else begin
            if (!m_ext && code == 8'h03) m_f5 = !m_rel;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 5; c++)
                    if (key_hit(code, m_ext, r, c)) m_mat[r][c] = m_rel;
            m_rel = 1'b0;
            m_ext = 1'b0;
        end
    endfunction

    function automatic logic [4:0] model_col(input logic [7:0] rsel);
        logic [4:0] v;
        v = 5'h1F;
        for (int r = 0; r < 8; r++)
            if (!rsel[r])
                for (int c = 0; c < 5; c++)
                    if (!m_mat[r][c]) v[c] = 1'b0;
        return v;
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            check("col_vs_model", col, model_col(row));
            check("f5_vs_model", {4'd0, f5}, {4'd0, m_f5});
        end
    end

    task automatic ps2_bit(input logic b);
        ps2D = b;
        repeat (H) @(posedge clock);
        #1 ps2Ck = 1'b0;
        repeat (H) @(posedge clock);
        #1 ps2Ck = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic stop_b, input logic bad_par);
        logic [10:0] f;
        f = {stop_b, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (i == 10) chk_en = 1'b0;
            ps2_bit(f[i]);
        end
        repeat (4) @(posedge clock);
        if (stop_b && !(bad_par && PAR_EN)) model_byte(code);
        #1 chk_en = 1'b1;
    endtask

    task automatic send_partial(input int n, input int idle);
        logic [10:0] f;
        f = {2'b11, 8'($urandom), 1'b0};
        for (int i = 0; i < n; i++) ps2_bit(f[i]);
        repeat (idle) @(posedge clock);
        #1;
    endtask

    task automatic lit(input string name, input logic [7:0] r, input logic [4:0] exp);
        row = r;
        @(negedge clock);
        check(name, col, exp);
        check({name, "_model"}, model_col(r), exp);
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #3 chk_en = 1'b0;
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock);
        #1 chk_en = 1'b1;
    endtask

    initial begin
        int k;
        int rr;
        int cc;
        logic [7:0] code;
        reset = 1'b1;
        ps2Ck = 1'b1;
        ps2D  = 1'b1;
        row   = 8'hFF;
        model_reset();
        #2 reset = 1'b0;
        #1;
        row = 8'h00;
        #1;
        check("por_col", col, 5'h1F);
        check("por_f5", {4'd0, f5}, 5'd0);
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock);
        #1 chk_en = 1'b1;
        lit("idle_all_rows", 8'h00, 5'h1F);

        // Z press and release
        send_frame(8'h1A, 1'b1, 1'b0);
        lit("z_press", 8'hFE, 5'h1D);
        send_frame(8'hF0, 1'b1, 1'b0);
        send_frame(8'h1A, 1'b1, 1'b0);
        lit("z_release", 8'hFE, 5'h1F);

        // Extended Left arrow = CS + 5
        send_frame(8'hE0, 1'b1, 1'b0);
        send_frame(8'h6B, 1'b1, 1'b0);
        lit("left_cs", 8'hFE, 5'h1E);
        lit("left_5", 8'hF7, 5'h0F);
        send_frame(8'hE0, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b1, 1'b0);
        send_frame(8'h6B, 1'b1, 1'b0);
        lit("left_rel_cs", 8'hFE, 5'h1F);
        lit("left_rel_5", 8'hF7, 5'h1F);

        // Bad stop bit, then a good frame
        send_frame(8'h1C, 1'b0, 1'b0);
        lit("bad_stop", 8'hFD, 5'h1F);
        send_frame(8'h1C, 1'b1, 1'b0);
        lit("a_press", 8'hFD, 5'h1E);
        send_frame(8'hF0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0);

        // Abandoned partial frame recovers after the timeout
        send_partial(4, int'(TO) + 1);
        send_frame(8'h29, 1'b1, 1'b0);
        lit("space_after_timeout", 8'h7F, 5'h1E);
        send_frame(8'hF0, 1'b1, 1'b0);
        send_frame(8'h29, 1'b1, 1'b0);

        // Wrong parity
        send_frame(8'h1A, 1'b1, 1'b1);
        lit("bad_parity", 8'hFE, PAR_EN ? 5'h1F : 5'h1D);
        send_frame(8'hF0, 1'b1, 1'b0);
        send_frame(8'h1A, 1'b1, 1'b0);
        lit("bad_parity_release", 8'hFE, 5'h1F);

        // Backspace = CS + 0
        send_frame(8'h66, 1'b1, 1'b0);
        lit("bksp", 8'hEE, 5'h1E);
        send_frame(8'hF0, 1'b1, 1'b0);
        send_frame(8'h66, 1'b1, 1'b0);

        // F5 and Z held, then async reset
        send_frame(8'h03, 1'b1, 1'b0);
        check("f5_press", {4'd0, f5}, 5'd1);
        send_frame(8'h1A, 1'b1, 1'b0);
        lit("z_held", 8'hFE, 5'h1D);
        @(posedge clock);
        #3 chk_en = 1'b0;
        reset = 1'b0;
        row = 8'h00;
        #1;
        check("rst_col", col, 5'h1F);
        check("rst_f5", {4'd0, f5}, 5'd0);
        model_reset();
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock);
        #1 chk_en = 1'b1;

        // Reset mid-frame discards the partial byte
        send_partial(5, 0);
        pulse_reset();
        send_frame(8'h22, 1'b1, 1'b0);
        lit("x_after_midreset", 8'hFE, 5'h1B);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            repeat (3) begin
                @(posedge clock);
                #1 row = 8'($urandom);
            end
            k = $urandom_range(0, 99);
            if (k < 3) begin
                send_partial($urandom_range(1, 10), int'(TO) + 5);
                continue;
            end
            if (k < 50) begin
                rr = $urandom_range(0, 7);
                cc = $urandom_range(0, 4);
                code = layout[rr][cc];
            end else if (k < 62) code = 8'hF0;
            else if (k < 72) code = 8'hE0;
            else if (k < 77) code = 8'h03;
            else if (k < 80) code = 8'h66;
            else if (k < 88) begin
                case ($urandom_range(0, 3))
                    0:       code = 8'h6B;
                    1:       code = 8'h72;
                    2:       code = 8'h75;
                    default: code = 8'h74;
                endcase
            end else code = 8'($urandom);
            send_frame(code, ($urandom_range(0, 19) != 0), ($urandom_range(0, 19) == 0));
        end

        repeat (5) @(posedge clock);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keyboard.md
KEYBOARD -- requirements
Module: keyboard

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd50000, the idle clock cycles mid-frame after which the PS/2 receiver abandons the frame.
REQ-002 SHALL have clock, input, 1, system clock; the only clock.
REQ-003 SHALL have reset, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have ps2Ck, input, 1, PS/2 clock, asynchronous to clock.
REQ-005 SHALL have ps2D, input, 1, PS/2 data, asynchronous to clock.
REQ-006 SHALL have row, input, 8, CPU A[15:8] row select, active low.
REQ-007 SHALL have col, output, 5, matrix column response to the ts core, active low.
REQ-008 SHALL have f5, output, 1, level-high while PS/2 F5 (0x03) is held; the top level uses it as the NMI request.

Function
REQ-009 SHALL synchronise ps2Ck and ps2D through two flops each and detect ps2Ck falling edges on the synchronised signal.
REQ-010 SHALL run the receiver FSM as follows: IDLE; DATA takes 8 bits LSB first; then PARITY; then STOP; each state advances on one ps2Ck falling edge.
REQ-011 SHALL leave IDLE only when the sampled start bit is 0; a 1 stays in IDLE.
REQ-012 SHALL discard a frame whose stop bit is 0 and return to IDLE.
REQ-013 SHALL return to IDLE with no decode when TIMEOUT clocks elapse without a falling edge outside IDLE; the counter clears on every falling edge.
REQ-014 SHALL decode an accepted byte on the clock after the STOP sample, so col reflects the key 3 clocks after the synchronised edge.
REQ-015 SHALL set the release flag on byte 0xF0 and the extend flag on 0xE0; any other byte is applied and then clears both flags.
REQ-016 SHALL hold a 40-bit matrix (8 rows x 5 cols, 1 = released); a press clears the mapped bits and a release sets them.
REQ-017 SHALL map the Spectrum layout with row index n = A(8+n): 0 CS Z X C V; 1 A S D F G; 2 Q W E R T; 3 1 2 3 4 5; 4 0 9 8 7 6; 5 P O I U Y; 6 Enter L K J H; 7 Space SS M N B; col bit 0 is the outermost key.
REQ-018 SHALL map Left Shift to CS (0,0) and Left Ctrl to SS (7,1).
REQ-019 SHALL map Backspace (0x66) to CS plus 0.
REQ-020 SHALL ignore unmapped bytes and bytes 0x00, 0xAA, 0xFA, 0xFC and 0xFE, apart from clearing the flags.
REQ-021 SHALL drive col[c] as the AND of matrix[r][c] over every r with row[r]=0, purely combinationally; row=0xFF gives col=5'h1F.
REQ-022 SHALL release both bits of a combo on its release code even if a bit is shared with another held key; this limitation is intended.

Reset
REQ-023 SHALL on reset set the FSM to IDLE, clear both flags and the timeout counter, set all matrix bits to 1, drive f5=0 and preset the synchroniser flops to 1.
REQ-024 SHALL treat reset mid-frame as discarding the partial byte, with no decode on release.

Configuration
REQ-025 SHALL with KEYBOARD_PARITY_EN defined check odd parity over data+parity and discard failing frames as in REQ-012.
REQ-026 SHALL without KEYBOARD_PARITY_EN sample and ignore the parity bit.
REQ-027 SHALL, with KEYBOARD_EXTENDED_EN not a configurable feature, always decode the E0 arrows as Left=CS+5, Down=CS+6, Up=CS+7, Right=CS+8.

Structure
REQ-028 SHALL place in package keyboard_pkg the FSM state enum, the constants KB_RELEASE=8'hF0 and KB_EXTEND=8'hE0, and a matrix position type {row[2:0], col[2:0], valid}.
REQ-029 SHALL have one combinational sub-module keymap: inputs {ext, code[7:0]}; outputs two positions, primary and optional secondary for combos.

Verification
REQ-030 SHALL verify: frame 0x1A (Z) with valid parity, row=0xFE -> col=5'h1D; then F0 1A -> col=5'h1F.
REQ-031 SHALL verify: E0 6B (Left) held, row=0xFE -> col=5'h1E and row=0xF7 -> col=5'h0F; E0 F0 6B releases both.
REQ-032 SHALL verify: stop bit 0 on frame 0x1C -> matrix unchanged, next valid frame 0x1C -> row=0xFD gives col=5'h1E.
REQ-033 SHALL verify: 4 bits sent, then idle for TIMEOUT+1 clocks, then full frame 0x29 -> Space pressed, with row=0x7F giving col=5'h1E.
REQ-034 SHALL verify with KEYBOARD_PARITY_EN: 0x1A with wrong parity -> ignored; without the macro -> accepted.
REQ-035 SHALL verify: reset asserted with keys 0x1A and 0x03 held -> col=5'h1F for row=0x00 and f5=0 immediately.
